// File: rtl/uart_tx_fifo_if.sv
// Bus-side and transmitter-side signals of the UART transmit byte queue.
// The master is the bus/transmitter environment and the slave is the queue itself.
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  ovf_clr;
    logic [7:0]            tx_data;
    logic                  tx_go;
    logic                  tx_bsy;

    modport master (
        output wr_en, wr_data, ovf_clr, tx_bsy,
        input  full, empty, count, overflow, tx_data, tx_go
    );

    modport slave (
        input  wr_en, wr_data, ovf_clr, tx_bsy,
        output full, empty, count, overflow, tx_data, tx_go
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte queue feeding a UART transmitter through a go/bsy/go-low handshake.
// The head byte stays queued until its frame completes, so count includes the byte in flight.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_fifo_if.slave   bus
);

    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE       = 3'b001,
        WAIT_START = 3'b010,
        BUSY       = 3'b100
    } state_t;

    state_t                 state;
    logic [DATA_W-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [DEPTH_LOG2:0]    count;
    logic                   overflow;
    logic [DATA_W-1:0]      tx_data;
    logic                   tx_go;

    logic                   full;
    logic                   empty;
    logic                   pop;
    logic                   push;
    logic                   ovf_set;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    // A pop frees the head slot in the same cycle, so a write at full is still accepted.
    assign pop     = (state == BUSY) && !bus.tx_bsy;
    assign push    = bus.wr_en && (!full || pop);
    assign ovf_set = bus.wr_en && full && !pop;

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count;
    assign bus.overflow = overflow;
    assign bus.tx_data  = tx_data;
    assign bus.tx_go    = tx_go;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (bus.ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // tx_go stays high through WAIT_START and BUSY; dropping it for one cycle after
    // each frame is what lets the transmitter rearm before the next request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx_go   <= 1'b0;
            tx_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        tx_data <= mem[rd_ptr];
                        tx_go   <= 1'b1;
                        state   <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (bus.tx_bsy) begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!bus.tx_bsy) begin
                        tx_go <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_go <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a UART transmitter model plus a queue-level reference model,
// table-driven fill/overflow vectors, and hand-written handshake and reset sequences.
module tb_uart_tx_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;
    localparam int BIT_TIME   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    int         frames_popped = 0;
    int         frames_done = 0;

    logic       hold_start = 1'b0;
    logic       stall = 1'b0;
    logic       t_busy = 1'b0;
    int         t_tick = 0;
    int         t_bit = 0;
    logic [7:0] t_cur = '0;
    logic [9:0] t_frame = '0;
    logic [9:0] last_frame = '0;
    logic [7:0] last_byte = '0;
    logic       go_low_seen = 1'b0;
    logic       prev_go = 1'b0;
    logic       want_rise = 1'b0;

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       ovf_clr;
        int         exp_count;
        logic       exp_full;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Queue-level reference: a byte is accepted if there is room or the head is
    // leaving this cycle; the head leaves on the first edge after its frame ends.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf = 1'b0;
            frames_popped = 0;
        end else begin
            automatic bit pop_m  = (frames_done > frames_popped);
            automatic bit full_m = (mq.size() == DEPTH);
            automatic bit hit    = bus.wr_en && full_m && !pop_m;
            if (pop_m) begin
                void'(mq.pop_front());
                frames_popped++;
            end
            if (bus.wr_en && !hit) begin
                mq.push_back(bus.wr_data);
            end
            if (hit) begin
                m_ovf = 1'b1;
            end else if (bus.ovf_clr) begin
                m_ovf = 1'b0;
            end
        end
    end

    // Transmitter model (acts on the falling edge) and per-cycle status comparison.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.tx_bsy  = 1'b0;
            t_busy      = 1'b0;
            t_tick      = 0;
            t_bit       = 0;
            frames_done = 0;
            go_low_seen = 1'b0;
            prev_go     = 1'b0;
            want_rise   = 1'b0;
        end else begin
            chk("count", 32'(bus.count), 32'(mq.size()));
            chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
            chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
            if (want_rise) begin
                chk("go_gap", 32'(bus.tx_go), 32'd1);
            end
            want_rise = prev_go && !bus.tx_go && (mq.size() > 0);
            prev_go   = bus.tx_go;

            if (!t_busy) begin
                if (!bus.tx_go) begin
                    go_low_seen = 1'b1;
                end else if (go_low_seen && !hold_start) begin
                    t_busy     = 1'b1;
                    bus.tx_bsy = 1'b1;
                    t_cur      = bus.tx_data;
                    t_tick     = 0;
                    t_bit      = 0;
                    t_frame    = '1;
                    t_frame[0] = 1'b0;
                end
            end else begin
                chk("tx_data_stable", 32'(bus.tx_data), 32'(t_cur));
                chk("go_hold", 32'(bus.tx_go), 32'd1);
                if (!stall) begin
                    t_tick++;
                    if (t_tick == BIT_TIME) begin
                        t_tick = 0;
                        t_bit++;
                        if (t_bit == 10) begin
                            t_busy      = 1'b0;
                            bus.tx_bsy  = 1'b0;
                            go_low_seen = 1'b0;
                            last_frame  = t_frame;
                            last_byte   = t_cur;
                            frames_done++;
                            if (mq.size() == 0) begin
                                timeout_fail("frame_without_queued_byte");
                            end else begin
                                chk("frame_byte", 32'(t_cur), 32'(mq[0]));
                            end
                        end else begin
                            t_frame[t_bit] = (t_bit <= 8) ? bus.tx_data[t_bit-1] : 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        cyc();
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_drained(input string name, input int bound);
        int n;
        n = 0;
        while (!(bus.empty && !bus.tx_bsy && mq.size() == 0) && n < bound) begin
            cyc();
            n++;
        end
        if (n >= bound) begin
            timeout_fail(name);
        end
    endtask

    task automatic wait_bsy(input string name);
        int n;
        n = 0;
        while (!bus.tx_bsy && n < 50) begin
            cyc();
            n++;
        end
        if (n >= 50) begin
            timeout_fail(name);
        end
    endtask

    initial begin
        int f0;
        int n;

        for (int i = 0; i < 16; i++) begin
            vecs[i].wr_en     = 1'b1;
            vecs[i].wr_data   = 8'(i);
            vecs[i].ovf_clr   = 1'b0;
            vecs[i].exp_count = i + 1;
            vecs[i].exp_full  = (i == 15);
            vecs[i].exp_ovf   = 1'b0;
        end
        vecs[16] = '{1'b1, 8'h10, 1'b0, 16, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 16, 1'b1, 1'b0};
        vecs[18] = '{1'b1, 8'h11, 1'b1, 16, 1'b1, 1'b1};
        vecs[19] = '{1'b0, 8'h00, 1'b1, 16, 1'b1, 1'b0};

        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.ovf_clr = 1'b0;

        repeat (3) cyc();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_tx_go", 32'(bus.tx_go), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        rst_n = 1'b1;
        repeat (2) cyc();

        // Single byte
        write(8'h55);
        chk("single_count", 32'(bus.count), 32'd1);
        chk("single_empty", 32'(bus.empty), 32'd0);
        chk("single_go_early", 32'(bus.tx_go), 32'd0);
        cyc();
        chk("single_go", 32'(bus.tx_go), 32'd1);
        chk("single_data", 32'(bus.tx_data), 32'h55);
        f0 = frames_done;
        n = 0;
        while (frames_done == f0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            timeout_fail("single_frame");
        end
        chk("single_go_after_bsy_fall", 32'(bus.tx_go), 32'd1);
        @(posedge clk);
        #1;
        chk("single_go_fall", 32'(bus.tx_go), 32'd0);
        chk("single_count_end", 32'(bus.count), 32'd0);
        chk("single_empty_end", 32'(bus.empty), 32'd1);
        chk("single_line", 32'(last_frame), 32'h2AA);

        // Burst of three
        f0 = frames_done;
        bus.wr_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.wr_data = 8'(i);
            cyc();
        end
        bus.wr_en = 1'b0;
        chk("burst_peak", 32'(bus.count), 32'd3);
        wait_drained("burst_drain", 400);
        chk("burst_frames", 32'(frames_done - f0), 32'd3);
        chk("burst_last", 32'(last_byte), 32'h03);

        // Fill and overflow with the transmitter held off
        hold_start = 1'b1;
        f0 = frames_done;
        for (int i = 0; i < 20; i++) begin
            bus.wr_en   = vecs[i].wr_en;
            bus.wr_data = vecs[i].wr_data;
            bus.ovf_clr = vecs[i].ovf_clr;
            cyc();
            bus.wr_en   = 1'b0;
            bus.ovf_clr = 1'b0;
            chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_full", i), 32'(bus.full), 32'(vecs[i].exp_full));
            chk($sformatf("vec%0d_ovf", i), 32'(bus.overflow), 32'(vecs[i].exp_ovf));
        end
        hold_start = 1'b0;
        wait_drained("full_drain", 1500);
        chk("full_frames", 32'(frames_done - f0), 32'd16);
        chk("full_last", 32'(last_byte), 32'h0F);

        // Push at full on the pop cycle
        f0 = frames_done;
        write(8'hA0);
        wait_bsy("pushpop_bsy");
        stall = 1'b1;
        for (int i = 1; i < 16; i++) begin
            write(8'hA0 + 8'(i));
        end
        chk("pushpop_count16", 32'(bus.count), 32'd16);
        chk("pushpop_full", 32'(bus.full), 32'd1);
        stall = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (bus.tx_bsy && n < 100);
        if (n >= 100) begin
            timeout_fail("pushpop_bsy_fall");
        end
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hB0;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        chk("pushpop_ovf", 32'(bus.overflow), 32'd0);
        chk("pushpop_count", 32'(bus.count), 32'd16);
        chk("pushpop_still_full", 32'(bus.full), 32'd1);
        wait_drained("pushpop_drain", 1500);
        chk("pushpop_frames", 32'(frames_done - f0), 32'd17);
        chk("pushpop_last", 32'(last_byte), 32'hB0);

        // Stream of 40 bytes across several pointer wraps
        f0 = frames_done;
        for (int i = 0; i < 40; i++) begin
            n = 0;
            while (mq.size() >= DEPTH - 1 && n < 200) begin
                cyc();
                n++;
            end
            if (n >= 200) begin
                timeout_fail("wrap_space");
            end
            write(8'(i));
        end
        wait_drained("wrap_drain", 3000);
        chk("wrap_frames", 32'(frames_done - f0), 32'd40);
        chk("wrap_last", 32'(last_byte), 32'h27);

        // Random writes, overflows and clears against the reference model
        for (int i = 0; i < 600; i++) begin
            bus.wr_en   = ($urandom_range(0, 7) == 0);
            bus.wr_data = 8'($urandom);
            bus.ovf_clr = ($urandom_range(0, 15) == 0);
            cyc();
        end
        bus.wr_en   = 1'b0;
        bus.ovf_clr = 1'b1;
        cyc();
        bus.ovf_clr = 1'b0;
        wait_drained("random_drain", 1500);

        // Asynchronous reset in the middle of a frame
        for (int i = 0; i < 5; i++) begin
            write(8'hC0 + 8'(i));
        end
        wait_bsy("reset_bsy");
        repeat (5) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_go", 32'(bus.tx_go), 32'd0);
        chk("reset_count", 32'(bus.count), 32'd0);
        chk("reset_empty", 32'(bus.empty), 32'd1);
        repeat (2) cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("post_reset_idle_go", 32'(bus.tx_go), 32'd0);
        end
        chk("post_reset_frames", 32'(frames_done), 32'd0);
        write(8'hD5);
        wait_drained("post_reset_drain", 400);
        chk("post_reset_frames_after", 32'(frames_done), 32'd1);
        chk("post_reset_last", 32'(last_byte), 32'hD5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
